// File: rtl/mips_pkg.sv
// Shared pipeline constants: datapath widths and load format codes.
// No logic and no latency.
// No flow control.
package mips_pkg;
   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   // Load format codes. Codes 5-7 are reserved and decode as LD_LW.
   localparam logic [2:0] LD_LW  = 3'd0;
   localparam logic [2:0] LD_LH  = 3'd1;
   localparam logic [2:0] LD_LHU = 3'd2;
   localparam logic [2:0] LD_LB  = 3'd3;
   localparam logic [2:0] LD_LBU = 3'd4;
endpackage

// File: rtl/mem_wb_if.sv
// MEM-stage to WB-stage bundle: captured inputs plus register file write port.
// No latency of its own.
// No backpressure; the stage accepts every cycle.
// With MEM_WB_RETIRE_CNT_EN defined the bundle also carries o_retire_cnt.
interface mem_wb_if;
   import mips_pkg::*;

   logic                i_valid;
   logic                i_flush;
   logic                i_wr_en;
   logic [REG_AW-1:0]   i_wr_reg;
   logic                i_mem_to_reg;
   logic [2:0]          i_load_type;
   logic [1:0]          i_addr_lo;
   logic [DATA_W-1:0]   i_alu_result;
   logic [DATA_W-1:0]   i_mem_rdata;
   logic [REG_AW-1:0]   o_wr_reg;
   logic [DATA_W-1:0]   o_data;
   logic                o_wr_control;
   logic                o_fwd_valid;
   logic                o_addr_err;
`ifdef MEM_WB_RETIRE_CNT_EN
   logic [31:0]         o_retire_cnt;
`endif

   // MEM stage side: drives the instruction, observes writeback.
   modport master (
      output i_valid, i_flush, i_wr_en, i_wr_reg, i_mem_to_reg,
             i_load_type, i_addr_lo, i_alu_result, i_mem_rdata,
`ifdef MEM_WB_RETIRE_CNT_EN
      input  o_retire_cnt,
`endif
      input  o_wr_reg, o_data, o_wr_control, o_fwd_valid, o_addr_err
   );

   // WB stage side.
   modport slave (
      input  i_valid, i_flush, i_wr_en, i_wr_reg, i_mem_to_reg,
             i_load_type, i_addr_lo, i_alu_result, i_mem_rdata,
`ifdef MEM_WB_RETIRE_CNT_EN
      output o_retire_cnt,
`endif
      output o_wr_reg, o_data, o_wr_control, o_fwd_valid, o_addr_err
   );
endinterface

// File: rtl/wb_load_align.sv
// Load-data extraction: picks the byte/halfword lane and sign/zero extends.
// Purely combinational, zero latency.
// No flow control.
module wb_load_align
   import mips_pkg::*;
(
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        addr_lo,
   input  logic [2:0]        load_type,
   output logic [DATA_W-1:0] data,
   output logic              mis
);
   logic [15:0] half;
   logic [7:0]  lane;

   // Lane selection is little-endian: lane n lives at bits [8n+7:8n].
   always_comb begin
      half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      lane = 8'(rdata >> {addr_lo, 3'b000});
      data = rdata;
      mis  = 1'b0;
      case (load_type)
         LD_LH: begin
            data = {{16{half[15]}}, half};
            mis  = addr_lo[0];
         end
         LD_LHU: begin
            data = {16'h0000, half};
            mis  = addr_lo[0];
         end
         LD_LB:   data = {{24{lane[7]}}, lane};
         LD_LBU:  data = {24'h000000, lane};
         default: mis  = (addr_lo != 2'b00);  // LW and reserved codes
      endcase
   end
endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with writeback formatting and forwarding view.
// One cycle from capture to outputs; outputs depend on stage registers only.
// No backpressure; flush kills the instruction being captured.
// Optional MEM_WB_RETIRE_CNT_EN adds a free-running retired-instruction counter.
module mem_wb
   import mips_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst,
   mem_wb_if.slave bus
);
   logic                r_valid;
   logic                r_wr_en;
   logic [REG_AW-1:0]   r_wr_reg;
   logic                r_mem_to_reg;
   logic [2:0]          r_load_type;
   logic [1:0]          r_addr_lo;
   logic [DATA_W-1:0]   r_alu_result;
   logic [DATA_W-1:0]   r_mem_rdata;

   logic [DATA_W-1:0]   load_data;
   logic                load_mis;
   logic                mis;

   // Stage register: reset clears everything, flush only kills validity.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid      <= 1'b0;
         r_wr_en      <= 1'b0;
         r_wr_reg     <= '0;
         r_mem_to_reg <= 1'b0;
         r_load_type  <= '0;
         r_addr_lo    <= '0;
         r_alu_result <= '0;
         r_mem_rdata  <= '0;
      end else if (bus.i_flush) begin
         r_valid      <= 1'b0;
      end else begin
         r_valid      <= bus.i_valid;
         r_wr_en      <= bus.i_wr_en;
         r_wr_reg     <= bus.i_wr_reg;
         r_mem_to_reg <= bus.i_mem_to_reg;
         r_load_type  <= bus.i_load_type;
         r_addr_lo    <= bus.i_addr_lo;
         r_alu_result <= bus.i_alu_result;
         r_mem_rdata  <= bus.i_mem_rdata;
      end
   end

   wb_load_align u_align (
      .rdata     (r_mem_rdata),
      .addr_lo   (r_addr_lo),
      .load_type (r_load_type),
      .data      (load_data),
      .mis       (load_mis)
   );

   // Misalignment only matters for loads; r0 is never written.
   assign mis              = r_mem_to_reg & load_mis;
   assign bus.o_addr_err   = r_valid & mis;
   assign bus.o_wr_control = r_valid & r_wr_en & (r_wr_reg != '0) & ~mis;
   assign bus.o_fwd_valid  = bus.o_wr_control;
   assign bus.o_wr_reg     = r_wr_reg;
   assign bus.o_data       = r_mem_to_reg ? load_data : r_alu_result;

`ifdef MEM_WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt;

   // Counts every instruction leaving WB that did not fault; wraps naturally.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         retire_cnt <= '0;
      else if (r_valid & ~bus.o_addr_err)
         retire_cnt <= retire_cnt + 32'd1;
   end

   assign bus.o_retire_cnt = retire_cnt;
`endif
endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: table vectors, hand sequences, random vs model.
// Checks are taken 1 time unit after each rising edge.
// Retire-counter checks are compiled only with MEM_WB_RETIRE_CNT_EN.
module tb_mem_wb;
   import mips_pkg::*;

   typedef struct {
      logic        rst;
      logic        valid;
      logic        flush;
      logic        wr_en;
      logic [4:0]  wr_reg;
      logic        m2r;
      logic [2:0]  lt;
      logic [1:0]  addr;
      logic [31:0] alu;
      logic [31:0] rdata;
   } in_t;

   typedef struct {
      string       name;
      in_t         in;
      logic        wc;
      logic        err;
      logic [31:0] data;
      logic        chk_data;
   } vec_t;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mem_wb_if bus ();

   mem_wb dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   // Reference state: the instruction sitting in WB, at spec level.
   in_t         m_cur;
   logic        m_valid;
   logic        m_known;
   logic [31:0] m_cnt;

   function automatic logic [31:0] model_data(input in_t r);
      int unsigned lt;
      int unsigned b, h;
      lt = (r.lt > 3'd4) ? 0 : int'(r.lt);
      b  = (r.rdata >> (8 * r.addr)) & 32'hFF;
      h  = (r.rdata >> (16 * r.addr[1])) & 32'hFFFF;
      if (!r.m2r) return r.alu;
      case (lt)
         1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
         2: return h;
         3: return (b >= 128) ? b + 32'hFFFFFF00 : b;
         4: return b;
         default: return r.rdata;
      endcase
   endfunction

   function automatic logic model_mis(input in_t r);
      int unsigned lt;
      lt = (r.lt > 3'd4) ? 0 : int'(r.lt);
      if (!r.m2r) return 1'b0;
      if (lt == 0) return r.addr != 0;
      if (lt == 1 || lt == 2) return r.addr % 2 == 1;
      return 1'b0;
   endfunction

   function automatic logic model_wc();
      return m_valid && m_cur.wr_en && m_cur.wr_reg != 0 && !model_mis(m_cur);
   endfunction

   function automatic logic model_err();
      return m_valid && model_mis(m_cur);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t v);
      i_rst            = v.rst;
      bus.i_valid      = v.valid;
      bus.i_flush      = v.flush;
      bus.i_wr_en      = v.wr_en;
      bus.i_wr_reg     = v.wr_reg;
      bus.i_mem_to_reg = v.m2r;
      bus.i_load_type  = v.lt;
      bus.i_addr_lo    = v.addr;
      bus.i_alu_result = v.alu;
      bus.i_mem_rdata  = v.rdata;
   endtask

   // Apply one cycle of inputs, advance the model across the edge.
   task automatic step(input in_t v);
      drive(v);
      @(posedge i_clk);
      if (v.rst) m_cnt = 32'd0;
      else if (m_valid && !model_err()) m_cnt = m_cnt + 32'd1;
      if (v.rst) begin
         m_cur = '{default: '0};
         m_valid = 1'b0;
         m_known = 1'b1;
      end else if (v.flush) begin
         m_valid = 1'b0;
         m_known = 1'b0;
      end else begin
         m_cur = v;
         m_valid = v.valid;
         m_known = 1'b1;
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".wr_control"}, 32'(bus.o_wr_control), 32'(model_wc()));
      chk({tag, ".fwd_valid"}, 32'(bus.o_fwd_valid), 32'(model_wc()));
      chk({tag, ".addr_err"}, 32'(bus.o_addr_err), 32'(model_err()));
      if (m_known) begin
         chk({tag, ".wr_reg"}, 32'(bus.o_wr_reg), 32'(m_cur.wr_reg));
         chk({tag, ".data"}, bus.o_data, model_data(m_cur));
      end
`ifdef MEM_WB_RETIRE_CNT_EN
      chk({tag, ".retire_cnt"}, bus.o_retire_cnt, m_cnt);
`endif
   endtask

   function automatic in_t mk(input logic valid, input logic wr_en, input logic [4:0] rg,
                              input logic m2r, input logic [2:0] lt, input logic [1:0] addr,
                              input logic [31:0] alu, input logic [31:0] rdata);
      in_t r;
      r = '{rst: 1'b0, valid: valid, flush: 1'b0, wr_en: wr_en, wr_reg: rg, m2r: m2r,
            lt: lt, addr: addr, alu: alu, rdata: rdata};
      return r;
   endfunction

   localparam logic [31:0] RD = 32'h80FF_7F01;

   vec_t vecs[$];
   in_t  bub;
   in_t  t;

   initial begin
      m_cur   = '{default: '0};
      m_valid = 1'b0;
      m_known = 1'b0;
      m_cnt   = 32'd0;
      bub     = mk(0, 0, 0, 0, LD_LW, 0, 0, 0);

      // Reset held with a live writing instruction on the inputs.
      t = mk(1, 1, 5'd5, 0, LD_LW, 0, 32'hAAAA_0005, 0);
      t.rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(t);
         chk("rst.wr_control", 32'(bus.o_wr_control), 0);
         chk("rst.fwd_valid", 32'(bus.o_fwd_valid), 0);
         chk("rst.addr_err", 32'(bus.o_addr_err), 0);
         chk("rst.wr_reg", 32'(bus.o_wr_reg), 0);
         chk("rst.data", bus.o_data, 0);
`ifdef MEM_WB_RETIRE_CNT_EN
         chk("rst.retire_cnt", bus.o_retire_cnt, 0);
`endif
      end
      t.rst = 1'b0;
      step(t);
      chk("post_rst.wr_control", 32'(bus.o_wr_control), 1);
      chk("post_rst.wr_reg", 32'(bus.o_wr_reg), 5);
      chk("post_rst.data", bus.o_data, 32'hAAAA_0005);
      step(bub);
      chk("post_rst_bubble.wr_control", 32'(bus.o_wr_control), 0);

      // Table: each vector is captured in one cycle and checked on the next.
      vecs.push_back('{"alu", mk(1,1,7,0,LD_LW,0,32'h1234_5678,RD), 1, 0, 32'h1234_5678, 1});
      vecs.push_back('{"lb3",  mk(1,1,9,1,LD_LB,3,0,RD),  1, 0, 32'hFFFF_FF80, 1});
      vecs.push_back('{"lbu3", mk(1,1,9,1,LD_LBU,3,0,RD), 1, 0, 32'h0000_0080, 1});
      vecs.push_back('{"lh2",  mk(1,1,9,1,LD_LH,2,0,RD),  1, 0, 32'hFFFF_80FF, 1});
      vecs.push_back('{"lhu0", mk(1,1,9,1,LD_LHU,0,0,RD), 1, 0, 32'h0000_7F01, 1});
      vecs.push_back('{"lw2",  mk(1,1,9,1,LD_LW,2,0,RD),  0, 1, RD, 1});
      vecs.push_back('{"lh1",  mk(1,1,9,1,LD_LH,1,0,RD),  0, 1, 32'h0000_7F01, 1});
      vecs.push_back('{"lw0",  mk(1,1,9,1,LD_LW,0,0,RD),  1, 0, RD, 1});
      vecs.push_back('{"lb1",  mk(1,1,9,1,LD_LB,1,0,RD),  1, 0, 32'h0000_007F, 1});
      vecs.push_back('{"lhu2", mk(1,1,9,1,LD_LHU,2,0,RD), 1, 0, 32'h0000_80FF, 1});
      vecs.push_back('{"rsv6", mk(1,1,9,1,3'd6,0,0,RD),   1, 0, RD, 1});
      vecs.push_back('{"r0",   mk(1,1,0,0,LD_LW,0,32'h55,RD), 0, 0, 32'h55, 1});
      vecs.push_back('{"nowr", mk(1,0,8,0,LD_LW,0,32'h66,RD), 0, 0, 32'h66, 1});
      vecs.push_back('{"bub",  mk(0,1,8,0,LD_LW,0,32'h77,RD), 0, 0, 32'h77, 1});
      t = mk(1,1,8,0,LD_LW,0,32'h88,RD);
      t.flush = 1'b1;
      vecs.push_back('{"flush", t, 0, 0, 0, 0});
      t = mk(0,1,8,1,LD_LW,1,0,RD);
      vecs.push_back('{"bub_mis", t, 0, 0, RD, 1});

      foreach (vecs[i]) begin
         step(vecs[i].in);
         chk({vecs[i].name, ".wr_control"}, 32'(bus.o_wr_control), 32'(vecs[i].wc));
         chk({vecs[i].name, ".fwd_valid"}, 32'(bus.o_fwd_valid), 32'(vecs[i].wc));
         chk({vecs[i].name, ".addr_err"}, 32'(bus.o_addr_err), 32'(vecs[i].err));
         if (vecs[i].chk_data) begin
            chk({vecs[i].name, ".wr_reg"}, 32'(bus.o_wr_reg), 32'(vecs[i].in.wr_reg));
            chk({vecs[i].name, ".data"}, bus.o_data, vecs[i].data);
         end
      end

      // Back-to-back writes to r3 then r4, then a bubble.
      step(mk(1,1,3,0,LD_LW,0,32'h3333_3333,0));
      chk("b2b.first.wr_control", 32'(bus.o_wr_control), 1);
      chk("b2b.first.wr_reg", 32'(bus.o_wr_reg), 3);
      chk("b2b.first.data", bus.o_data, 32'h3333_3333);
      step(mk(1,1,4,0,LD_LW,0,32'h4444_4444,0));
      chk("b2b.second.wr_control", 32'(bus.o_wr_control), 1);
      chk("b2b.second.wr_reg", 32'(bus.o_wr_reg), 4);
      chk("b2b.second.data", bus.o_data, 32'h4444_4444);
      step(bub);
      chk("b2b.after.wr_control", 32'(bus.o_wr_control), 0);

      // Reset mid-stream: the instruction on the inputs in the reset cycle is lost.
      t = mk(1,1,6,0,LD_LW,0,32'h6666,0);
      step(t);
      chk("midrst.pre.wr_control", 32'(bus.o_wr_control), 1);
      t.rst = 1'b1;
      step(t);
      chk("midrst.rst.wr_control", 32'(bus.o_wr_control), 0);
      t.rst = 1'b0;
      t.valid = 1'b0;
      step(t);
      chk("midrst.after.wr_control", 32'(bus.o_wr_control), 0);

`ifdef MEM_WB_RETIRE_CNT_EN
      // 10 valid, 1 bubble, 1 misaligned load after a reset -> 10 retired.
      t = bub;
      t.rst = 1'b1;
      step(t);
      for (int i = 0; i < 10; i++) step(mk(1, i % 2, 5'(i), 0, LD_LW, 0, 32'(i), 0));
      step(bub);
      step(mk(1,1,2,1,LD_LW,2,0,RD));
      step(bub);
      step(bub);
      chk("retire.ten", bus.o_retire_cnt, 32'd10);
      force dut.retire_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt;
      m_cnt = 32'hFFFF_FFFF;
      step(mk(1,1,2,0,LD_LW,0,0,0));
      chk("retire.hold", bus.o_retire_cnt, 32'hFFFF_FFFF);
      step(bub);
      chk("retire.wrap", bus.o_retire_cnt, 32'd0);
`endif

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         t.rst    = ($urandom_range(0, 31) == 0);
         t.flush  = ($urandom_range(0, 7) == 0);
         t.valid  = ($urandom_range(0, 3) != 0);
         t.wr_en  = ($urandom_range(0, 3) != 0);
         t.wr_reg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         t.m2r    = 1'($urandom);
         t.lt     = 3'($urandom_range(0, 7));
         t.addr   = 2'($urandom);
         t.alu    = $urandom;
         t.rdata  = $urandom;
         step(t);
         check_model("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_wb.md
Name: mem_wb

Overview:
- Final pipeline stage: MEM/WB pipeline register plus writeback formatting.
- Captures MEM-stage results and applies load-data extraction (byte/halfword, signed/unsigned).
- Selects ALU result vs load data and drives the register file write port (write register, write data, write enable).
- Exposes the same registered writeback for EX-stage forwarding; flags misaligned loads.

Parameters:
- DATA_W, 32, datapath width (only 32 supported)
- REG_AW, 5, register index width

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; synchronous, active-high
- i_valid  input  1  MEM stage presents a valid instruction this cycle
- i_flush  input  1  discard the instruction being captured this cycle
- i_wr_en  input  1  instruction writes a GPR
- i_mem_to_reg  input  1  1 = write load data, 0 = write ALU result
- i_load_type  input  3  load format code (see package)
- i_addr_lo  input  2  low bits of the effective address
- i_alu_result  input  32  EX/MEM ALU result
- i_mem_rdata  input  32  raw data-memory read word
- o_wr_reg  output  5  register file write index
- o_data  output  32  register file write data
- o_wr_control  output  1  register file write enable
- o_fwd_valid  output  1  forwarding entry valid (equals o_wr_control)
- o_addr_err  output  1  misaligned load in WB this cycle

Behaviour:
- Single register stage; latency 1 cycle from capture to outputs.
- Every posedge i_clk:
  - If i_rst: all stage registers 0, so r_valid = 0.
  - Else if i_flush: r_valid <= 0; other fields don't-care.
  - Else: capture all inputs, r_valid <= i_valid.
- i_flush has priority over i_valid.
- i_rst has priority over everything. Reset mid-stream drops the in-flight instruction; no write occurs in the reset cycle or the cycle after.
- Reset values: o_wr_reg = 0, o_data = 0, o_wr_control = 0, o_fwd_valid = 0, o_addr_err = 0.
- Outputs are combinational from stage registers only, with no input-to-output path.
- Byte order is little-endian; lane n = bits [8n+7:8n].
- Load formatting (when r_mem_to_reg = 1):
  - LW: word unchanged.
  - LH / LHU: halfword at r_addr_lo[1] (0 = [15:0], 1 = [31:16]), sign- or zero-extended to 32.
  - LB / LBU: byte at r_addr_lo, sign- or zero-extended.
  - Codes 5-7 are reserved and treated as LW.
- o_data = formatted load data if r_mem_to_reg, else r_alu_result.
- Misalignment:
  - mis = r_mem_to_reg & ((LW & r_addr_lo != 0) | ((LH|LHU) & r_addr_lo[0])).
  - o_addr_err = r_valid & mis.
- o_wr_control = r_valid & r_wr_en & (r_wr_reg != 0) & ~mis.
- Register r0 is never written, even when requested.
- o_wr_reg always equals r_wr_reg; it is only meaningful when o_wr_control = 1.
- Back-to-back valid instructions each produce exactly one write cycle.
- A bubble (i_valid = 0) produces o_wr_control = 0.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN.
- Defined:
  - Adds output o_retire_cnt, 32 bits.
  - Increments by 1 on every cycle with r_valid & ~o_addr_err, including non-writing instructions.
  - Wraps 0xFFFFFFFF -> 0; cleared by i_rst.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package mips_pkg:
  - Load type localparams: LD_LW = 3'd0, LD_LH = 3'd1, LD_LHU = 3'd2, LD_LB = 3'd3, LD_LBU = 3'd4.
  - DATA_W and REG_AW defaults.
- One combinational sub-module, wb_load_align: inputs rdata, addr_lo, load_type; outputs aligned data and misaligned flag. Instantiated once.

Test Plan:
- Reset: hold i_rst = 1 with i_valid = 1, i_wr_en = 1, i_wr_reg = 5 -> all outputs 0. Deassert -> write to reg 5 appears on the next cycle only.
- ALU writeback: i_valid = 1, i_wr_en = 1, i_wr_reg = 7, i_mem_to_reg = 0, i_alu_result = 0x1234_5678 -> next cycle o_wr_control = 1, o_wr_reg = 7, o_data = 0x1234_5678.
- Loads with i_mem_rdata = 0x80FF_7F01:
  - LB, addr_lo = 3 -> 0xFFFF_FF80.
  - LBU, addr_lo = 3 -> 0x0000_0080.
  - LH, addr_lo = 2 -> 0xFFFF_80FF.
  - LHU, addr_lo = 0 -> 0x0000_7F01.
- Misaligned: LW with addr_lo = 2 -> o_addr_err = 1, o_wr_control = 0. LH with addr_lo = 1 -> same.
- r0 and flush:
  - i_wr_reg = 0, i_wr_en = 1 -> o_wr_control = 0.
  - i_valid = 1 with i_flush = 1 -> o_wr_control = 0 next cycle.
  - Back-to-back writes to reg 3 then reg 4 -> two consecutive write cycles in order.
- Retire counter (macro defined): 10 valid instructions, 1 bubble, 1 misaligned load -> o_retire_cnt = 10. Force the counter to 0xFFFFFFFF, then 1 instruction -> 0.
